// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB-Lite bus arbiter with bus parking, locked
// transfers and a fairness hold limit for unlocked owners.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset (overrides hready)
//   hbusreq    per-master bus request
//   hlock      per-master locked-access request
//   hready     transfer completes this cycle; 0 freezes all state
//   htrans     HTRANS of the current address-phase master
//   hgrant     one-hot grant (registered)
//   hmaster    address-phase owner index, lags hgrant by one transfer (registered)
//   hmastlock  current address-phase transfer is locked (registered)
module ahb_arbiter #(
  parameter int unsigned NMASTER        = 4,
  parameter int unsigned MW             = 2,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NMASTER-1:0] hbusreq,
  input  logic [NMASTER-1:0] hlock,
  input  logic               hready,
  input  logic [1:0]         htrans,
  output logic [NMASTER-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic               hmastlock
);

  localparam int unsigned  HW          = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);
  localparam logic [MW-1:0] DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [1:0]    HTRANS_BUSY = 2'b01;
  localparam logic [1:0]    HTRANS_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t          state;
  logic [MW-1:0]   owner;
  logic [MW-1:0]   last_owner;
  logic [HW-1:0]   hold_cnt;
  logic            lock_tail;

  logic [MW-1:0]   winner_c;
  logic            found_c;
  logic            any_req_c;
  logic            others_req_c;
  logic            owner_req_c;
  logic            owner_lock_c;
  logic            in_burst_c;
  logic            hold_hit_c;
  logic            do_arb_c;
  logic            do_park_c;

  // Round-robin search: first requester after last_owner, wrapping to last_owner itself.
  always_comb begin
    winner_c = last_owner;
    found_c  = 1'b0;
    for (int unsigned i = 1; i <= NMASTER; i++) begin
      logic [MW-1:0] idx;
      idx = MW'((32'(last_owner) + i) % NMASTER);
      if (!found_c && hbusreq[idx]) begin
        winner_c = idx;
        found_c  = 1'b1;
      end
    end
  end

  // Decide whether this hready cycle re-arbitrates or parks the bus.
  always_comb begin
    any_req_c    = |hbusreq;
    others_req_c = |(hbusreq & ~hgrant);
    owner_req_c  = hbusreq[owner];
    owner_lock_c = hlock[owner];
    in_burst_c   = (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
    hold_hit_c   = (hold_cnt == HOLD_LAST) && others_req_c && !in_burst_c;
    do_arb_c     = 1'b0;
    do_park_c    = 1'b0;
    unique case (state)
      ST_PARK: begin
        do_arb_c = any_req_c;
      end
      ST_OWNED: begin
        if (!any_req_c) begin
          do_park_c = 1'b1;
        end else if (!owner_req_c || hold_hit_c) begin
          do_arb_c = 1'b1;
        end
      end
      ST_LOCKED: begin
        // Leave only after the extra cycle that completes the final locked transfer.
        if (!owner_lock_c && lock_tail) begin
          do_arb_c  = any_req_c;
          do_park_c = !any_req_c;
        end
      end
      default: begin
        do_park_c = 1'b1;
      end
    endcase
  end

  // State, grant and address-phase outputs; everything advances only on hready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_PARK;
      owner      <= DEF_IDX;
      last_owner <= DEF_IDX;
      hold_cnt   <= '0;
      lock_tail  <= 1'b0;
      hgrant     <= NMASTER'(1) << DEF_IDX;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
    end else if (hready) begin
      hmaster   <= owner;
      hmastlock <= owner_lock_c;
      if (do_park_c) begin
        state     <= ST_PARK;
        owner     <= DEF_IDX;
        hgrant    <= NMASTER'(1) << DEF_IDX;
        hold_cnt  <= '0;
        lock_tail <= 1'b0;
      end else if (do_arb_c) begin
        state      <= hlock[winner_c] ? ST_LOCKED : ST_OWNED;
        owner      <= winner_c;
        last_owner <= winner_c;
        hgrant     <= NMASTER'(1) << winner_c;
        hold_cnt   <= '0;
        lock_tail  <= 1'b0;
      end else begin
        unique case (state)
          ST_OWNED: begin
            if (owner_lock_c) begin
              state     <= ST_LOCKED;
              lock_tail <= 1'b0;
            end else if (hold_cnt != HOLD_LAST) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            lock_tail <= !owner_lock_c;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a behavioural arbitration model.
module tb_ahb_arbiter;

  localparam int N       = 4;
  localparam int DM      = 0;
  localparam int MAXH    = 16;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] hbusreq = '0;
  logic [N-1:0] hlock = '0;
  logic         hready = 1'b1;
  logic [1:0]   htrans = T_IDLE;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int total = 0;
  int bad   = 0;

  // reference model: bus owner, who owned last, how long, and lock phase
  int m_own, m_mst, m_mlk, m_hold, m_last;
  bit m_parked, m_locked, m_tail;

  ahb_arbiter #(.NMASTER(N), .MW(2), .DEFAULT_MASTER(DM), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .hbusreq(hbusreq), .hlock(hlock), .hready(hready),
    .htrans(htrans), .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) begin
      if (req[(last + i) % N]) return (last + i) % N;
    end
    return last;
  endfunction

  task automatic m_give(input int w);
    m_own = w; m_last = w; m_hold = 0; m_tail = 0;
    m_parked = 0; m_locked = hlock[w];
  endtask

  task automatic m_park();
    m_own = DM; m_hold = 0; m_tail = 0; m_parked = 1; m_locked = 0;
  endtask

  task automatic m_reset();
    m_own = DM; m_mst = DM; m_mlk = 0; m_hold = 0; m_last = DM;
    m_parked = 1; m_locked = 0; m_tail = 0;
  endtask

  // one clock of the specified arbitration rules, using inputs present at the edge
  task automatic m_step();
    bit others;
    if (reset) begin m_reset(); return; end
    if (!hready) return;
    m_mst = m_own;
    m_mlk = hlock[m_own];
    others = (hbusreq & ~(N'(1) << m_own)) != 0;
    if (m_parked) begin
      if (hbusreq != 0) m_give(rr_pick(hbusreq, m_last));
    end else if (m_locked) begin
      if (hlock[m_own]) m_tail = 0;
      else if (!m_tail) m_tail = 1;
      else if (hbusreq != 0) m_give(rr_pick(hbusreq, m_last));
      else m_park();
    end else begin
      if (hbusreq == 0) m_park();
      else if (!hbusreq[m_own]) m_give(rr_pick(hbusreq, m_last));
      else if (m_hold == MAXH - 1 && others && htrans != T_SEQ && htrans != 2'b01)
        m_give(rr_pick(hbusreq, m_last));
      else if (hlock[m_own]) begin m_locked = 1; m_tail = 0; end
      else if (m_hold < MAXH - 1) m_hold++;
    end
  endtask

  // apply inputs, clock once, advance model, compare outputs just after the edge
  task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lk, input logic rdy,
                     input logic [1:0] tr, input logic rs);
    hbusreq = rq; hlock = lk; hready = rdy; htrans = tr; reset = rs;
    @(posedge clk);
    m_step();
    #1;
    chk("grant", 32'(hgrant), 32'(N'(1) << m_own));
    chk("hmaster", 32'(hmaster), 32'(m_mst));
    chk("hmastlock", 32'(hmastlock), 32'(m_mlk));
    chk("onehot", 32'($countones(hgrant)), 32'd1);
  endtask

  task automatic do_reset();
    cyc('0, '0, 1'b1, T_IDLE, 1'b1);
    cyc('0, '0, 1'b1, T_IDLE, 1'b1);
  endtask

  initial begin
    logic [N-1:0] rq, lk;
    logic [N-1:0] rot [0:4];
    m_reset();

    // idle bus parks on the default master
    do_reset();
    repeat (10) cyc('0, '0, 1'b1, T_IDLE, 1'b0);
    chk("t1_grant", 32'(hgrant), 32'h1);
    chk("t1_hmaster", 32'(hmaster), 32'h0);
    chk("t1_lock", 32'(hmastlock), 32'h0);

    // request handover with hmaster trailing by one transfer
    do_reset();
    cyc(4'b0110, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t2_g1", 32'(hgrant), 32'b0010);
    chk("t2_m0", 32'(hmaster), 32'd0);
    cyc(4'b0110, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t2_m1", 32'(hmaster), 32'd1);
    cyc(4'b0100, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t2_g2", 32'(hgrant), 32'b0100);
    cyc(4'b0100, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t2_m2", 32'(hmaster), 32'd2);

    // fairness rotation every MAX_HOLD cycles
    do_reset();
    rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001; rot[4] = 4'b0010;
    cyc(4'b1111, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t3_first", 32'(hgrant), 32'(rot[0]));
    for (int k = 0; k < 4; k++) begin
      repeat (MAXH - 1) cyc(4'b1111, '0, 1'b1, T_NSEQ, 1'b0);
      chk("t3_hold", 32'(hgrant), 32'(rot[k]));
      cyc(4'b1111, '0, 1'b1, T_NSEQ, 1'b0);
      chk("t3_rot", 32'(hgrant), 32'(rot[k+1]));
    end

    // locked owner ignores others and hold limit, releases one cycle after hlock drops
    do_reset();
    cyc(4'b0100, 4'b0100, 1'b1, T_NSEQ, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(4'b1111, 4'b0100, 1'b1, T_NSEQ, 1'b0);
      chk("t4_grant", 32'(hgrant), 32'b0100);
      chk("t4_lock", 32'(hmastlock), 32'd1);
    end
    cyc(4'b1111, 4'b0000, 1'b1, T_NSEQ, 1'b0);
    chk("t4_tail", 32'(hgrant), 32'b0100);
    cyc(4'b1111, 4'b0000, 1'b1, T_NSEQ, 1'b0);
    chk("t4_next", 32'(hgrant), 32'b1000);

    // hready low freezes a pending grant change
    do_reset();
    repeat (5) begin
      cyc(4'b0010, '0, 1'b0, T_NSEQ, 1'b0);
      chk("t5_frz_g", 32'(hgrant), 32'b0001);
      chk("t5_frz_m", 32'(hmaster), 32'd0);
    end
    cyc(4'b0010, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t5_go", 32'(hgrant), 32'b0010);

    // no handover mid-burst at hold limit; reset overrides hready low
    do_reset();
    cyc(4'b0010, '0, 1'b1, T_NSEQ, 1'b0);
    repeat (30) cyc(4'b0011, '0, 1'b1, T_SEQ, 1'b0);
    chk("t6_burst", 32'(hgrant), 32'b0010);
    cyc(4'b0011, '0, 1'b1, T_NSEQ, 1'b0);
    chk("t6_brk", 32'(hgrant), 32'b0001);
    cyc(4'b0011, '0, 1'b1, T_NSEQ, 1'b0);
    cyc(4'b0011, '0, 1'b0, T_SEQ, 1'b1);
    chk("t6_rst_g", 32'(hgrant), 32'b0001);
    chk("t6_rst_m", 32'(hmaster), 32'd0);

    // randomized traffic with sticky requests and locks
    do_reset();
    rq = '0; lk = '0;
    for (int c = 0; c < 4000; c++) begin
      logic rdy, rs;
      logic [1:0] tr;
      if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 11) == 0) lk[$urandom_range(0, N-1)] ^= 1'b1;
      rdy = ($urandom_range(0, 6) != 0);
      tr  = 2'($urandom_range(0, 3));
      rs  = ($urandom_range(0, 799) == 0);
      cyc(rq, lk, rdy, tr, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
